wb_arb: RTL

//  Writeback arbiter between the EX pipes and the single PRF write port / ROB writeback port.

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_arb_if.sv | 44 ++++
 rtl/wb_rr_arb.sv | 36 +++
 rtl/wb_arb.sv | 86 ++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared writeback widths and bundle-size helper
package wb_arb_pkg;
    localparam int DEF_NUM_IN = 2;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_ROB_DEPTH = 4;
    localparam int DEF_COMMIT_WIDTH = 1;
    localparam int NCPU_PRF_AW = 6;
    localparam int WB_FLAG_W = 3;
    function automatic int wb_data_w(input int aw, input int dw, input int rd, input int cw);
        return NCPU_PRF_AW + dw + rd + cw + aw + dw;
    endfunction
endpackage

// File: rtl/wb_arb_if.sv
// wb_arb_if: EX-pipe writeback inputs and PRF/ROB writeback outputs
interface wb_arb_if
    import wb_arb_pkg::*;
#(
    parameter int N  = DEF_NUM_IN,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int RD = DEF_ROB_DEPTH,
    parameter int CW = DEF_COMMIT_WIDTH
) ();
    logic [N-1:0]             in_valid;
    logic [N-1:0]             in_ready;
    logic [N*RD-1:0]          in_rob_id;
    logic [N*CW-1:0]          in_rob_bank;
    logic [N-1:0]             in_prf_we;
    logic [N*NCPU_PRF_AW-1:0] in_prf_waddr;
    logic [N*DW-1:0]          in_prf_wdata;
    logic [N-1:0]             in_fls;
    logic [N-1:0]             in_exc;
    logic [N*AW-1:0]          in_opera;
    logic [N*DW-1:0]          in_operb;
    logic                     prf_WE;
    logic [NCPU_PRF_AW-1:0]   prf_WADDR;
    logic [DW-1:0]            prf_WDATA;
    logic                     rob_wb_valid;
    logic [RD-1:0]            rob_wb_id;
    logic [CW-1:0]            rob_wb_bank;
    logic                     rob_wb_fls;
    logic                     rob_wb_exc;
    logic [AW-1:0]            rob_wb_opera;
    logic [DW-1:0]            rob_wb_operb;
    modport master (
        output in_valid, in_rob_id, in_rob_bank, in_prf_we, in_prf_waddr, in_prf_wdata,
               in_fls, in_exc, in_opera, in_operb,
        input  in_ready, prf_WE, prf_WADDR, prf_WDATA, rob_wb_valid, rob_wb_id, rob_wb_bank,
               rob_wb_fls, rob_wb_exc, rob_wb_opera, rob_wb_operb
    );
    modport slave (
        input  in_valid, in_rob_id, in_rob_bank, in_prf_we, in_prf_waddr, in_prf_wdata,
               in_fls, in_exc, in_opera, in_operb,
        output in_ready, prf_WE, prf_WADDR, prf_WDATA, rob_wb_valid, rob_wb_id, rob_wb_bank,
               rob_wb_fls, rob_wb_exc, rob_wb_opera, rob_wb_operb
    );
endinterface

// File: rtl/wb_rr_arb.sv
// wb_rr_arb: round-robin one-hot grant with encoded index; pointer moves past each grant
module wb_rr_arb
    import wb_arb_pkg::*;
#(
    parameter int N = DEF_NUM_IN,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          found;
    int            idx;
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        rr_ptr_d = found ? ((gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/wb_arb.sv
// wb_arb: per-pipe skid buffers feeding one registered PRF/ROB writeback port, round-robin
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int CONFIG_AW = DEF_AW,
    parameter int CONFIG_DW = DEF_DW,
    parameter int CONFIG_P_ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int CONFIG_P_COMMIT_WIDTH = DEF_COMMIT_WIDTH
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    wb_arb_if.slave  bus
);
    localparam int PA = NCPU_PRF_AW;
    localparam int RD = CONFIG_P_ROB_DEPTH;
    localparam int CW = CONFIG_P_COMMIT_WIDTH;
    localparam int BW = wb_data_w(CONFIG_AW, CONFIG_DW, RD, CW);
    localparam int IW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
    logic [NUM_IN-1:0]    buf_vld_q, buf_vld_d, req, xfer, gnt, arb_req;
    logic [IW-1:0]        gnt_idx;
    logic [BW-1:0]        live_dat [NUM_IN];
    logic [BW-1:0]        src_dat [NUM_IN];
    logic [BW-1:0]        buf_dat_q [NUM_IN];
    logic [BW-1:0]        buf_dat_d [NUM_IN];
    logic [WB_FLAG_W-1:0] live_flg [NUM_IN];
    logic [WB_FLAG_W-1:0] src_flg [NUM_IN];
    logic [WB_FLAG_W-1:0] buf_flg_q [NUM_IN];
    logic [WB_FLAG_W-1:0] buf_flg_d [NUM_IN];
    logic [BW-1:0]        out_dat_q, out_dat_d;
    logic [WB_FLAG_W-1:0] out_flg_q, out_flg_d;
    logic                 valid_q, valid_d;
    assign req = buf_vld_q | bus.in_valid;
    assign xfer = bus.in_valid & ~buf_vld_q;
    // Masking requests during flush keeps the round-robin pointer where it was
    assign arb_req = flush ? '0 : req;
    assign bus.in_ready = ~buf_vld_q;
    for (genvar g = 0; g < NUM_IN; g++) begin : g_pipe
        assign live_dat[g] = {bus.in_prf_waddr[g*PA +: PA], bus.in_prf_wdata[g*CONFIG_DW +: CONFIG_DW],
                              bus.in_rob_id[g*RD +: RD], bus.in_rob_bank[g*CW +: CW],
                              bus.in_opera[g*CONFIG_AW +: CONFIG_AW], bus.in_operb[g*CONFIG_DW +: CONFIG_DW]};
        assign live_flg[g] = {bus.in_prf_we[g], bus.in_fls[g], bus.in_exc[g]};
        assign src_dat[g] = buf_vld_q[g] ? buf_dat_q[g] : live_dat[g];
        assign src_flg[g] = buf_vld_q[g] ? buf_flg_q[g] : live_flg[g];
    end
    wb_rr_arb #(.N(NUM_IN)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );
    always_comb begin
        out_dat_d = src_dat[gnt_idx];
        out_flg_d = flush ? '0 : src_flg[gnt_idx] & {WB_FLAG_W{|req}};
        valid_d = ~flush & |req;
        buf_vld_d = flush ? '0 : (buf_vld_q | xfer) & ~gnt;
        for (int i = 0; i < NUM_IN; i++) begin
            buf_dat_d[i] = (xfer[i] & ~gnt[i]) ? live_dat[i] : buf_dat_q[i];
            buf_flg_d[i] = (xfer[i] & ~gnt[i]) ? live_flg[i] : buf_flg_q[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld_q <= '0;
            valid_q <= 1'b0;
            out_flg_q <= '0;
        end else begin
            buf_vld_q <= buf_vld_d;
            valid_q <= valid_d;
            out_flg_q <= out_flg_d;
        end
    end
    always_ff @(posedge clk) begin
        out_dat_q <= out_dat_d;
        buf_dat_q <= buf_dat_d;
        buf_flg_q <= buf_flg_d;
    end
    assign bus.rob_wb_valid = valid_q;
    assign bus.prf_WE = out_flg_q[2];
    assign bus.rob_wb_fls = out_flg_q[1];
    assign bus.rob_wb_exc = out_flg_q[0];
    assign {bus.prf_WADDR, bus.prf_WDATA, bus.rob_wb_id, bus.rob_wb_bank,
            bus.rob_wb_opera, bus.rob_wb_operb} = out_dat_q;
endmodule
